// File: rtl/cpu6502_pkg.sv
// Shared 6502 definitions: word-fetch FSM states, interrupt vector addresses and bus widths.
package cpu6502_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [15:0] NMI_VEC = 16'hFFFA;
  localparam logic [15:0] RST_VEC = 16'hFFFC;
  localparam logic [15:0] IRQ_VEC = 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    DONE     = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/word_fetch_if.sv
// Control handshake plus memory bus of the word fetcher; slave = fetcher, master = its environment.
interface word_fetch_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) ();

  logic                  start;
  logic [ADDR_W-1:0]     addr;
  logic                  busy;
  logic                  done;
  logic [2*DATA_W-1:0]   word;
  logic [ADDR_W-1:0]     bus_addr;
  logic                  bus_rd;
  logic [DATA_W-1:0]     bus_data;
  logic                  bus_rdy;

  modport slave (
    input  start, addr, bus_data, bus_rdy,
    output busy, done, word, bus_addr, bus_rd
  );

  modport master (
    output start, addr, bus_data, bus_rdy,
    input  busy, done, word, bus_addr, bus_rd
  );

endinterface

// File: rtl/word_fetch.sv
// Assembles a 16-bit little-endian word from two consecutive byte reads.
// WORD_FETCH_PAGE_WRAP_EN: high-byte address wraps inside the page (NMOS JMP ($xxFF) bug).
module word_fetch
  import cpu6502_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  word_fetch_if.slave fetch
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [2*DATA_W-1:0] r_word;

  // r_addr is the live bus address: base in FETCH_LO, high-byte address from FETCH_HI onward.
`ifdef WORD_FETCH_PAGE_WRAP_EN
  assign w_addr_hi = {r_addr[ADDR_W-1:8], r_addr[7:0] + 8'd1};
`else
  assign w_addr_hi = r_addr + ADDR_W'(1);
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (fetch.start)   w_state_nxt = FETCH_LO;
      FETCH_LO: if (fetch.bus_rdy) w_state_nxt = FETCH_HI;
      FETCH_HI: if (fetch.bus_rdy) w_state_nxt = DONE;
      DONE:                        w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_lo   <= '0;
      r_word <= '0;
    end else begin
      if (r_state == IDLE && fetch.start) begin
        r_addr <= fetch.addr;
      end
      if (r_state == FETCH_LO && fetch.bus_rdy) begin
        r_lo   <= fetch.bus_data;
        r_addr <= w_addr_hi;
      end
      if (r_state == FETCH_HI && fetch.bus_rdy) begin
        r_word <= {fetch.bus_data, r_lo};
      end
    end
  end

  assign fetch.busy     = (r_state != IDLE);
  assign fetch.done     = (r_state == DONE);
  assign fetch.bus_rd   = (r_state == FETCH_LO) || (r_state == FETCH_HI);
  assign fetch.bus_addr = r_addr;
  assign fetch.word     = r_word;

endmodule

// File: tb/tb_word_fetch.sv
// Self-checking bench for word_fetch: memory model, scoreboard queues, one task per scenario.
module tb_word_fetch;
  import cpu6502_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  word_fetch_if #(.ADDR_W(ADDR_W_DEF), .DATA_W(DATA_W_DEF)) fif ();

  word_fetch #(.ADDR_W(ADDR_W_DEF), .DATA_W(DATA_W_DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fetch (fif.slave)
  );

  logic [7:0] mem [0:65535];
  always_comb fif.bus_data = mem[fif.bus_addr];

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_word_q [$];
  logic [15:0] exp_addr_q [$];
  logic [15:0] rd_log     [$];
  logic [15:0] done_log   [$];

  // Inputs change at posedge+2, so the falling edge sees what the next rising edge will sample.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fif.bus_rd && fif.bus_rdy) rd_log.push_back(fif.bus_addr);
      if (fif.done) done_log.push_back(fif.word);
    end
  end

  function automatic logic [15:0] hi_of(input logic [15:0] a);
`ifdef WORD_FETCH_PAGE_WRAP_EN
    return {a[15:8], a[7:0] + 8'd1};
`else
    return a + 16'd1;
`endif
  endfunction

  function automatic logic [15:0] model_word(input logic [15:0] a);
    return {mem[hi_of(a)], mem[a]};
  endfunction

  task automatic clear_logs();
    exp_word_q.delete();
    exp_addr_q.delete();
    rd_log.delete();
    done_log.delete();
  endtask

  // Call at posedge+2; returns at posedge+2 after the start-sampling edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] expw);
    exp_word_q.push_back(expw);
    exp_addr_q.push_back(a);
    exp_addr_q.push_back(hi_of(a));
    fif.addr  = a;
    fif.start = 1'b1;
    @(posedge clk);
    #2;
    fif.start = 1'b0;
    fif.addr  = 16'($urandom);
  endtask

  // Edges counted from the start-sampling edge; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (fif.done) return;
    end
    cyc = -1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (fif.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", fif.busy); end
    n_vec++; if (fif.done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", fif.done); end
    n_vec++; if (fif.bus_rd !== 1'b0) begin n_err++; $display("FAIL reset bus_rd: got %b want 0", fif.bus_rd); end
    n_vec++;
    if (fif.bus_addr !== 16'h0000) begin
      n_err++; $display("FAIL reset bus_addr: got %h want 0000", fif.bus_addr);
    end
    n_vec++; if (fif.word !== 16'h0000) begin n_err++; $display("FAIL reset word: got %h want 0000", fif.word); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset_vector();
    int cyc;
    logic [15:0] got, exp;
    clear_logs();
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'hC0;
    launch(RST_VEC, 16'hC000);
    wait_done(cyc);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL rstvec latency: got %0d want 3", cyc); end
    @(negedge clk); #1;
    n_vec++;
    if (done_log.size() == 0) begin n_err++; $display("FAIL rstvec word: got no done want %h", exp_word_q[0]); end
    else begin
      got = done_log.pop_front(); exp = exp_word_q.pop_front();
      if (got !== exp) begin n_err++; $display("FAIL rstvec word: got %h want %h", got, exp); end
    end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      exp = exp_addr_q.pop_front();
      if (rd_log.size() == 0) begin n_err++; $display("FAIL rstvec addr%0d: got none want %h", i, exp); end
      else begin
        got = rd_log.pop_front();
        if (got !== exp) begin n_err++; $display("FAIL rstvec addr%0d: got %h want %h", i, got, exp); end
      end
    end
    @(posedge clk); #2;
  endtask

  task automatic test_wait_states();
    int cyc;
    logic [15:0] got, exp;
    logic rdy_pat [2:5];
    rdy_pat = '{1'b0, 1'b1, 1'b0, 1'b1};
    clear_logs();
    fif.bus_rdy = 1'b0;
    launch(16'h1234, model_word(16'h1234));
    cyc = -1;
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk); #1;
      if (fif.done) begin cyc = k; break; end
      exp = (k <= 3) ? 16'h1234 : hi_of(16'h1234);
      n_vec++;
      if (fif.bus_addr !== exp || fif.bus_rd !== 1'b1) begin
        n_err++; $display("FAIL wait addr k=%0d: got %h rd=%b want %h rd=1", k, fif.bus_addr, fif.bus_rd, exp);
      end
      #1 fif.bus_rdy = (k <= 5) ? rdy_pat[k] : 1'b1;
    end
    fif.bus_rdy = 1'b1;
    n_vec++; if (cyc !== 6) begin n_err++; $display("FAIL wait latency: got %0d want 6", cyc); end
    @(negedge clk); #1;
    n_vec++;
    if (done_log.size() == 0) begin n_err++; $display("FAIL wait word: got no done want %h", exp_word_q[0]); end
    else begin
      got = done_log.pop_front(); exp = exp_word_q.pop_front();
      if (got !== exp) begin n_err++; $display("FAIL wait word: got %h want %h", got, exp); end
    end
    n_vec++;
    if (rd_log.size() !== 2) begin n_err++; $display("FAIL wait reads: got %0d want 2", rd_log.size()); end
    @(posedge clk); #2;
  endtask

  task automatic test_page_boundary();
    int cyc;
    logic [15:0] got, exp;
    clear_logs();
    mem[16'h02FF] = 8'h34;
    mem[16'h0300] = 8'h12;
    mem[16'h0200] = 8'h56;
`ifdef WORD_FETCH_PAGE_WRAP_EN
    exp = 16'h5634;
`else
    exp = 16'h1234;
`endif
    launch(16'h02FF, exp);
    wait_done(cyc);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL page latency: got %0d want 3", cyc); end
    @(negedge clk); #1;
    n_vec++;
    if (done_log.size() == 0) begin n_err++; $display("FAIL page word: got no done want %h", exp); end
    else begin
      got = done_log.pop_front(); exp = exp_word_q.pop_front();
      if (got !== exp) begin n_err++; $display("FAIL page word: got %h want %h", got, exp); end
    end
    @(posedge clk); #2;
  endtask

  task automatic test_addr_wrap();
    int cyc;
    logic [15:0] got, exp;
    clear_logs();
    mem[16'hFFFF] = 8'hAA;
    mem[16'h0000] = 8'hBB;
    launch(16'hFFFF, model_word(16'hFFFF));
    wait_done(cyc);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL wrap latency: got %0d want 3", cyc); end
    @(negedge clk); #1;
    n_vec++;
    if (done_log.size() == 0) begin n_err++; $display("FAIL wrap word: got no done want %h", exp_word_q[0]); end
    else begin
      got = done_log.pop_front(); exp = exp_word_q.pop_front();
      if (got !== exp) begin n_err++; $display("FAIL wrap word: got %h want %h", got, exp); end
    end
    void'(exp_addr_q.pop_front());
    exp = exp_addr_q.pop_front();
    n_vec++;
    if (rd_log.size() != 2) begin n_err++; $display("FAIL wrap reads: got %0d want 2", rd_log.size()); end
    else if (rd_log[1] !== exp) begin n_err++; $display("FAIL wrap hi addr: got %h want %h", rd_log[1], exp); end
    @(posedge clk); #2;
  endtask

  task automatic test_ignored_start();
    int cyc;
    logic [15:0] got, exp;
    clear_logs();
    launch(16'h0400, model_word(16'h0400));
    @(posedge clk); #2;                 // now FETCH_HI
    fif.start = 1'b1;
    fif.addr  = 16'h0700;
    @(posedge clk); #2;                 // now DONE, start still high
    @(posedge clk); #2;                 // back in IDLE
    fif.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_vec++; if (done_log.size() !== 1) begin n_err++; $display("FAIL ign dones: got %0d want 1", done_log.size()); end
    n_vec++; if (fif.busy !== 1'b0) begin n_err++; $display("FAIL ign busy: got %b want 0", fif.busy); end
    n_vec++;
    if (fif.bus_addr !== hi_of(16'h0400)) begin
      n_err++; $display("FAIL ign idle addr: got %h want %h", fif.bus_addr, hi_of(16'h0400));
    end
    n_vec++;
    if (done_log.size() == 0) begin n_err++; $display("FAIL ign word: got no done want %h", exp_word_q[0]); end
    else begin
      got = done_log.pop_front(); exp = exp_word_q.pop_front();
      if (got !== exp) begin n_err++; $display("FAIL ign word: got %h want %h", got, exp); end
    end
    #1;
    launch(16'h0410, model_word(16'h0410));
    wait_done(cyc);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL ign next latency: got %0d want 3", cyc); end
    n_vec++;
    if (fif.word !== exp_word_q[0]) begin
      n_err++; $display("FAIL ign next word: got %h want %h", fif.word, exp_word_q[0]);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_reset_midop();
    int cyc;
    logic [15:0] exp;
    clear_logs();
    launch(16'h0500, model_word(16'h0500));
    @(posedge clk); #2;                 // now FETCH_HI
    rst_n = 1'b0;
    #1;
    n_vec++; if (fif.bus_rd !== 1'b0) begin n_err++; $display("FAIL midrst bus_rd: got %b want 0", fif.bus_rd); end
    n_vec++; if (fif.busy !== 1'b0) begin n_err++; $display("FAIL midrst busy: got %b want 0", fif.busy); end
    n_vec++; if (fif.word !== 16'h0000) begin n_err++; $display("FAIL midrst word: got %h want 0000", fif.word); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_vec++; if (done_log.size() !== 0) begin n_err++; $display("FAIL midrst done: got %0d want 0", done_log.size()); end
    clear_logs();
    #1;
    exp = model_word(16'h0600);
    launch(16'h0600, exp);
    wait_done(cyc);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL midrst fresh latency: got %0d want 3", cyc); end
    n_vec++; if (fif.word !== exp) begin n_err++; $display("FAIL midrst fresh word: got %h want %h", fif.word, exp); end
    @(posedge clk); #2;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    fif.start   = 1'b0;
    fif.addr    = '0;
    fif.bus_rdy = 1'b1;
    test_reset();
    test_reset_vector();
    test_wait_states();
    test_page_boundary();
    test_addr_wrap();
    test_ignored_start();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
